// File: rtl/bcd_countdown_timer_pkg.sv
// Shared clock-module definitions: FSM state encoding and BCD digit constants.
package bcd_countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam logic [3:0] BCD_NINE = 4'd9;

   function automatic logic [3:0] bcd_clamp(input logic [3:0] val, input logic [3:0] limit,
                                            input logic [3:0] repl);
      return (val > limit) ? repl : val;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade down-counter: loads a value, or steps down on en and wraps to wrap_val from zero.
module bcd_digit_down
   import bcd_countdown_timer_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic [3:0] wrap_val,
   output logic [3:0] q,
   output logic       borrow
);

   logic [3:0] q_q;
   logic [3:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         q_d = (q_q == BCD_ZERO) ? wrap_val : q_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= BCD_ZERO;
      end else begin
         q_q <= q_d;
      end
   end

   assign q      = q_q;
   assign borrow = en && (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown stage (mm or ss) with start/pause/load control and a one-cycle expiry pulse.
module bcd_countdown_timer
   import bcd_countdown_timer_pkg::*;
#(
   parameter logic [3:0] MAX_TENS = 4'd5,
   parameter logic [3:0] MAX_ONES = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       start,
   input  logic       pause,
   output logic [3:0] cnt_tens,
   output logic [3:0] cnt_ones,
   output logic       busy,
   output logic       done
);

   state_e     state_q;
   state_e     state_d;
   logic       done_q;
   logic       done_d;

   logic [3:0] tens_val;
   logic [3:0] ones_val;
   logic [3:0] tens_clamped;
   logic [3:0] ones_clamped;
   logic       load_en;
   logic       dec_en;
   logic       ones_borrow;
   logic       tens_borrow;
   logic       cnt_is_zero;
   logic       cnt_is_one;

   assign tens_clamped = bcd_clamp(load_tens, MAX_TENS, MAX_TENS);
   assign ones_clamped = bcd_clamp(load_ones, BCD_NINE, MAX_ONES);

   assign cnt_is_zero = (tens_val == BCD_ZERO) && (ones_val == BCD_ZERO);
   assign cnt_is_one  = (tens_val == BCD_ZERO) && (ones_val == 4'd1);

   // Pause in the same cycle as a tick suppresses the decrement; 00 is never stepped.
   assign load_en = load && (state_q != ST_RUN);
   assign dec_en  = (state_q == ST_RUN) && tick && !pause && !cnt_is_zero;

   bcd_digit_down u_ones (
      .clk      (clk),
      .rst      (rst),
      .en       (dec_en),
      .load     (load_en),
      .load_val (ones_clamped),
      .wrap_val (MAX_ONES),
      .q        (ones_val),
      .borrow   (ones_borrow)
   );

   // A tens borrow would be an underflow; it pins tens at zero instead of wrapping.
   bcd_digit_down u_tens (
      .clk      (clk),
      .rst      (rst),
      .en       (ones_borrow),
      .load     (load_en || tens_borrow),
      .load_val (tens_borrow ? BCD_ZERO : tens_clamped),
      .wrap_val (MAX_TENS),
      .q        (tens_val),
      .borrow   (tens_borrow)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!load && start && !pause && !cnt_is_zero) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (pause) begin
               state_d = ST_PAUSED;
            end else if (tick && cnt_is_one) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_PAUSED: begin
            if (load) begin
               state_d = ST_IDLE;
            end else if (start && !pause) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (load) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign cnt_tens = tens_val;
   assign cnt_ones = ones_val;
   assign busy     = (state_q == ST_RUN);
   assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: directed vectors push expected outputs, a monitor compares them.
module tb_bcd_countdown_timer;

   logic       clk;
   logic       rst;
   logic       tick;
   logic       load;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   logic       start;
   logic       pause;
   logic [3:0] cnt_tens;
   logic [3:0] cnt_ones;
   logic       busy;
   logic       done;

   typedef struct {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   bcd_countdown_timer #(.MAX_TENS(4'd5), .MAX_ONES(4'd9)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .load      (load),
      .load_tens (load_tens),
      .load_ones (load_ones),
      .start     (start),
      .pause     (pause),
      .cnt_tens  (cnt_tens),
      .cnt_ones  (cnt_ones),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge and queue what the outputs must be after the next rising edge.
   task automatic applyStimulus(input logic r, input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                                input logic st, input logic ps, input logic tk,
                                input logic [3:0] et, input logic [3:0] eo, input logic eb, input logic ed,
                                input string nm);
      exp_t e;
      @(negedge clk);
      rst       = r;
      load      = ld;
      load_tens = lt;
      load_ones = lo;
      start     = st;
      pause     = ps;
      tick      = tk;
      e.tens = et;
      e.ones = eo;
      e.busy = eb;
      e.done = ed;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (cnt_tens !== e.tens || cnt_ones !== e.ones || busy !== e.busy || done !== e.done) begin
         errors++;
         $display("[TB] FAIL %s: got tens=%0d ones=%0d busy=%b done=%b, expected tens=%0d ones=%0d busy=%b done=%b",
                  e.name, cnt_tens, cnt_ones, busy, done, e.tens, e.ones, e.busy, e.done);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      int wait_cycles;
      rst = 1'b1; tick = 1'b0; load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
      start = 1'b0; pause = 1'b0;

      // Reset mid-run
      applyStimulus(1, 0, 0, 0, 0, 0, 0,  4'd0, 4'd0, 0, 0, "reset");
      applyStimulus(0, 1, 0, 5, 0, 0, 0,  4'd0, 4'd5, 0, 0, "load_05");
      applyStimulus(0, 0, 0, 0, 1, 0, 0,  4'd0, 4'd5, 1, 0, "start_05");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd0, 4'd4, 1, 0, "tick_04");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd0, 4'd3, 1, 0, "tick_03");
      applyStimulus(1, 0, 0, 0, 0, 0, 1,  4'd0, 4'd0, 0, 0, "rst_mid_run");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd0, 4'd0, 0, 0, "idle_after_rst");

      // Borrow across the tens digit
      applyStimulus(0, 1, 2, 0, 0, 0, 0,  4'd2, 4'd0, 0, 0, "load_20");
      applyStimulus(0, 0, 0, 0, 1, 0, 0,  4'd2, 4'd0, 1, 0, "start_20");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd1, 4'd9, 1, 0, "borrow_19");
      for (int i = 1; i <= 9; i++)
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd1, 4'(9 - i), 1, 0, "count_1x");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd0, 4'd9, 1, 0, "borrow_09");
      applyStimulus(0, 0, 0, 0, 0, 1, 0,  4'd0, 4'd9, 0, 0, "pause_09");

      // Expiry and DONE hold
      applyStimulus(0, 1, 0, 2, 0, 0, 0,  4'd0, 4'd2, 0, 0, "load_02_paused");
      applyStimulus(0, 0, 0, 0, 1, 0, 0,  4'd0, 4'd2, 1, 0, "start_02");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd0, 4'd1, 1, 0, "tick_01");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd0, 4'd0, 0, 1, "expiry");
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0, "done_hold");
      applyStimulus(0, 0, 0, 0, 1, 0, 0,  4'd0, 4'd0, 0, 0, "done_start_ign");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd0, 4'd0, 0, 0, "done_still");

      // Pause/resume and simultaneous events
      applyStimulus(0, 1, 3, 0, 0, 0, 0,  4'd3, 4'd0, 0, 0, "load_30_done");
      applyStimulus(0, 0, 0, 0, 1, 0, 0,  4'd3, 4'd0, 1, 0, "start_30");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd2, 4'd9, 1, 0, "tick_29");
      applyStimulus(0, 0, 0, 0, 0, 1, 1,  4'd2, 4'd9, 0, 0, "pause_tick");
      for (int i = 0; i < 5; i++)
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd2, 4'd9, 0, 0, "paused_tick");
      applyStimulus(0, 0, 0, 0, 1, 0, 0,  4'd2, 4'd9, 1, 0, "resume");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd2, 4'd8, 1, 0, "tick_28");
      applyStimulus(0, 0, 0, 0, 0, 1, 0,  4'd2, 4'd8, 0, 0, "pause_28");
      applyStimulus(0, 0, 0, 0, 1, 1, 0,  4'd2, 4'd8, 0, 0, "pause_beats_start");
      applyStimulus(0, 1, 1, 5, 0, 0, 1,  4'd1, 4'd5, 0, 0, "load_tick_paused");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd1, 4'd5, 0, 0, "idle_tick_ign");
      applyStimulus(0, 1, 4, 4, 1, 0, 0,  4'd4, 4'd4, 0, 0, "load_beats_start");

      // Clamp, and load ignored while running
      applyStimulus(0, 1, 7, 12, 0, 0, 0, 4'd5, 4'd9, 0, 0, "clamp_59");
      applyStimulus(0, 0, 0, 0, 1, 0, 0,  4'd5, 4'd9, 1, 0, "start_59");
      applyStimulus(0, 1, 1, 1, 0, 0, 0,  4'd5, 4'd9, 1, 0, "load_in_run_ign");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd5, 4'd8, 1, 0, "tick_58");
      applyStimulus(0, 0, 0, 0, 0, 1, 0,  4'd5, 4'd8, 0, 0, "pause_58");
      applyStimulus(0, 1, 3, 10, 0, 0, 0, 4'd3, 4'd9, 0, 0, "clamp_ones_39");

      // Zero start never runs or expires
      applyStimulus(1, 0, 0, 0, 0, 0, 0,  4'd0, 4'd0, 0, 0, "reset2");
      applyStimulus(0, 0, 0, 0, 1, 0, 0,  4'd0, 4'd0, 0, 0, "zero_start");
      applyStimulus(0, 0, 0, 0, 0, 0, 1,  4'd0, 4'd0, 0, 0, "zero_tick");
      applyStimulus(0, 0, 0, 0, 1, 0, 1,  4'd0, 4'd0, 0, 0, "zero_start_tick");
      applyStimulus(0, 0, 0, 0, 0, 0, 0,  4'd0, 4'd0, 0, 0, "zero_quiet");

      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 20) begin
         @(posedge clk);
         wait_cycles++;
      end
      #2;
      if (sb.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
